// File: rtl/nn_pkg.sv
// Constants and types shared by the classifier datapath (top_nn) and its
// input loader.
package nn_pkg;

    localparam int IN_SIZE  = 26;
    localparam int DATA_W   = 8;
    localparam int OUT_SIZE = 10;

    typedef logic signed [DATA_W-1:0] feature_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } loader_state_t;

endpackage

// File: rtl/feature_vector_loader.sv
// Assembles a framed stream of signed features into the parallel input_vector
// for top_nn, handing it off with a valid/ready handshake.
module feature_vector_loader #(
    parameter int IN_SIZE = 26,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] input_vector [0:IN_SIZE-1],
    output logic                     vec_valid,
    input  logic                     vec_ready,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         frame_cnt
);

    import nn_pkg::*;

    localparam int                IDX_W    = $clog2(IN_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_SIZE - 1);

    loader_state_t            state;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] feature_buf [0:IN_SIZE-1];
    logic                     beat;

    assign beat         = s_valid && s_ready;
    assign input_vector = feature_buf;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            s_ready   <= 1'b0;
            vec_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            // NOTE: the buffer is reset explicitly so an aborted frame can
            // never leak old features into a later vector.
            for (int i = 0; i < IN_SIZE; i++) begin
                feature_buf[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (beat) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (s_last) begin
                                feature_buf[idx] <= s_data;
                                state            <= HOLD;
                                vec_valid        <= 1'b1;
                                s_ready          <= 1'b0;
                            end else begin
                                // Overlong frame: discard the rest up to s_last.
                                frame_err <= 1'b1;
                                state     <= DROP;
                            end
                        end else if (s_last) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            feature_buf[idx] <= s_data;
                            idx              <= idx + 1'b1;
                        end
                    end
                end
                DROP: begin
                    s_ready <= 1'b1;
                    if (beat && s_last) begin
                        state <= FILL;
                    end
                end
                HOLD: begin
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
                        s_ready   <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= FILL;
                    end
                end
                default: begin
                    state   <= FILL;
                    idx     <= '0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_vector_loader.sv
// Directed self-checking bench for feature_vector_loader; inputs change and
// outputs are sampled on the falling clock edge.
module tb_feature_vector_loader;

    localparam int N = 26;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic signed [7:0] iv [0:N-1];
    logic              vec_valid;
    logic              vec_ready = 1'b0;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_vec [0:N-1];

    feature_vector_loader #(.IN_SIZE(N), .DATA_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .input_vector (iv),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Presents one beat and returns at the falling edge after it was accepted.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $error("FAIL s_ready_timeout observed=0 expected=1");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int bubble_max);
        for (int i = 0; i < N; i++) begin
            send(exp_vec[i], i == N - 1);
            if (bubble_max > 0) repeat ($urandom_range(0, bubble_max)) @(negedge clk);
        end
    endtask

    task automatic check_vector(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s[%0d]", tag, i), {24'b0, iv[i]}, {24'b0, exp_vec[i]});
        end
    endtask

    task automatic handshake(input int delay, input logic [15:0] cnt_exp);
        repeat (delay) begin
            @(negedge clk);
            check("hold_vec_valid", vec_valid, 1);
        end
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        check("hs_vec_valid", vec_valid, 0);
        check("hs_s_ready", s_ready, 1);
        check("hs_frame_cnt", frame_cnt, cnt_exp);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_iv0", {24'b0, iv[0]}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_s_ready", s_ready, 1);

        // Frame -13..12, held with vec_ready low
        for (int i = 0; i < N; i++) exp_vec[i] = 8'(i - 13);
        send_frame(0);
        check("a_vec_valid", vec_valid, 1);
        check("a_s_ready", s_ready, 0);
        check("a_iv0", {24'b0, iv[0]}, 32'h0000_00F3);
        check("a_iv13", {24'b0, iv[13]}, 32'h0000_0000);
        check("a_iv25", {24'b0, iv[25]}, 32'h0000_000C);
        check_vector("a_vec");
        s_data  = 8'sh11;
        s_valid = 1'b1;
        s_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("a_hold_valid", vec_valid, 1);
            check("a_hold_iv0", {24'b0, iv[0]}, 32'h0000_00F3);
            check("a_hold_iv25", {24'b0, iv[25]}, 32'h0000_000C);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        handshake(0, 16'd1);

        // vec_ready with no vector pending is ignored
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        check("idle_ready_cnt", frame_cnt, 1);
        check("idle_ready_valid", vec_valid, 0);

        // All 0x7F frame
        for (int i = 0; i < N; i++) exp_vec[i] = 8'h7F;
        send_frame(0);
        check("b_vec_valid", vec_valid, 1);
        check_vector("b_vec");
        handshake(2, 16'd2);

        // Short frame: s_last on beat 10
        for (int i = 0; i < 10; i++) begin
            send(8'(i + 1), i == 9);
            check("short_err", frame_err, i == 9);
            check("short_vec_valid", vec_valid, 0);
        end
        @(negedge clk);
        check("short_err_drop", frame_err, 0);
        for (int i = 0; i < N; i++) exp_vec[i] = 8'(i * 3);
        send_frame(0);
        check("c_vec_valid", vec_valid, 1);
        check_vector("c_vec");
        handshake(1, 16'd3);

        // Long frame: 30 beats, s_last on beat 30
        for (int i = 0; i < 30; i++) begin
            send(8'(8'h40 + i), i == 29);
            check("long_err", frame_err, i == 25);
            check("long_vec_valid", vec_valid, 0);
        end
        for (int i = 0; i < N; i++) exp_vec[i] = 8'(100 - i);
        send_frame(0);
        check("d_vec_valid", vec_valid, 1);
        check_vector("d_vec");
        handshake(0, 16'd4);

        // Random bubbles and random consumer delay
        for (int i = 0; i < N; i++) exp_vec[i] = 8'(i * 7 - 50);
        send_frame(3);
        check("e_vec_valid", vec_valid, 1);
        check_vector("e_vec");
        handshake($urandom_range(0, 20), 16'd5);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 15; i++) send(8'h55, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_s_ready", s_ready, 0);
        check("arst_vec_valid", vec_valid, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_iv3", {24'b0, iv[3]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("arst_rel_s_ready", s_ready, 0);
        for (int i = 0; i < N; i++) exp_vec[i] = 8'h80;
        send_frame(0);
        check("f_vec_valid", vec_valid, 1);
        check_vector("f_vec");
        handshake(0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/feature_vector_loader.md
Name: feature_vector_loader

Overview:
Producer side of the classifier input interface. Collects a byte stream of signed 8-bit features (one beat per feature, frame delimited by s_last) into a buffer of IN_SIZE entries. Presents the buffer as the parallel input_vector consumed by top_nn, using a valid/ready handshake. Sits between the feature source (preprocessing or host link) and top_nn, and replaces file preloading of input_vector in system-level use.

Parameters:
IN_SIZE, 26, number of features per frame (entries of input_vector)
DATA_W, 8, feature width in bits, signed two's complement
CNT_W, 16, width of the accepted-frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_data  in  DATA_W signed  feature beat
s_valid  in  1  s_data/s_last valid
s_last  in  1  marks final beat of a frame
s_ready  out  1  loader accepts a beat this cycle
input_vector  out  IN_SIZE x DATA_W signed, unpacked [0:IN_SIZE-1]  assembled feature vector
vec_valid  out  1  input_vector complete and stable
vec_ready  in  1  consumer has taken the vector
frame_err  out  1  one-cycle pulse on a malformed frame
frame_cnt  out  CNT_W  count of vectors handed off; wraps at 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FILL, idx=0, all buffer entries 0
  - s_ready=0, vec_valid=0, frame_err=0, frame_cnt=0
  - s_ready rises on the first clk edge after release.
- All outputs are registered. input_vector is driven directly from the buffer and is guaranteed only while vec_valid=1.
- Beat accepted = s_valid && s_ready at a rising edge.
- State FILL (s_ready=1):
  - accepted beat with idx<IN_SIZE-1 and s_last=0: buf[idx]<=s_data, idx++.
  - accepted beat with idx<IN_SIZE-1 and s_last=1 (short frame): frame_err pulses next cycle, idx<=0, stay FILL, vec_valid stays 0.
  - accepted beat with idx==IN_SIZE-1 and s_last=1: buf[idx]<=s_data, idx<=0, state<=HOLD, vec_valid<=1, s_ready<=0 on the same edge. Latency: vec_valid is high the cycle after the last beat.
  - accepted beat with idx==IN_SIZE-1 and s_last=0 (long frame): frame_err pulses, idx<=0, state<=DROP, and that beat is discarded.
- State DROP (s_ready=1):
  - consume and discard beats; on an accepted beat with s_last=1, go to FILL.
  - no frame_err pulse in DROP beyond the initial one.
- State HOLD (s_ready=0, vec_valid=1):
  - input_vector held constant. s_valid is ignored.
  - on vec_ready=1: vec_valid<=0, s_ready<=1, frame_cnt<=frame_cnt+1 (modulo 2^CNT_W), state<=FILL.
  - the next frame can be accepted from the cycle after the handshake.
- vec_ready while vec_valid=0 has no effect.
- s_valid may toggle arbitrarily; bubbles do not affect idx.
- Reset mid-frame discards the partial frame. Reset during HOLD drops the pending vector without counting it.
- No arithmetic on data. Features are stored bit-exact.

Decomposition:
- Shared package nn_pkg holds:
  - IN_SIZE, DATA_W and OUT_SIZE constants, shared with top_nn
  - typedef feature_t (logic signed [DATA_W-1:0])
  - enum loader_state_t {FILL, HOLD, DROP}
- Single module; no sub-module is warranted. The buffer is a plain register array and the FSM is the only control.

Test Plan:
- Reset, then stream 26 beats with values -13..12 and s_last on beat 26, vec_ready=0 -> vec_valid=1 the cycle after beat 26. input_vector[0]=8'hF3, [13]=8'h00, [25]=8'h0C. s_ready=0; vector stable for 10 held cycles.
- From that state pulse vec_ready for 1 cycle -> vec_valid=0 and s_ready=1 next cycle, frame_cnt=1. A second frame of 26 beats of 8'h7F -> all 26 entries 8'h7F, frame_cnt=2 after handshake.
- Short frame with s_last on beat 10 -> frame_err high exactly 1 cycle, no vec_valid. A following good frame of 26 beats is delivered correctly.
- Long frame of 30 beats with s_last on beat 30 -> frame_err pulse after beat 26, beats 26-30 dropped, no vec_valid. The next good frame is delivered correctly and frame_cnt increments by 1 only.
- Good frame with random 0-3 cycle s_valid bubbles and random vec_ready delay 0-20 cycles -> vector identical to the bubble-free case; no beat lost or duplicated.
- Assert rst_n low after 15 beats -> all outputs at reset values asynchronously. After release, a full frame of 8'h80 yields all entries 8'h80 with no residue from the aborted frame; frame_cnt=1 after handshake.
